// File: rtl/iob_ram_t2p_fifo_ctrl.sv
// Synchronous FIFO controller driving an external true two-port RAM (read latency 1).
// Define IOB_RAM_T2P_FIFO_CTRL_ERR_EN to add sticky overflow/underflow flags (err_o, err_clr_i).
module iob_ram_t2p_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              w_en_i,
   input  logic [DATA_W-1:0] w_data_i,
   output logic              w_full_o,
   input  logic              r_en_i,
   output logic [DATA_W-1:0] r_data_o,
   output logic              r_valid_o,
   output logic              r_empty_o,
   output logic [ADDR_W:0]   level_o,
   output logic              ext_mem_clk_o,
   output logic              ext_mem_w_en_o,
   output logic [ADDR_W-1:0] ext_mem_w_addr_o,
   output logic [DATA_W-1:0] ext_mem_w_data_o,
   output logic              ext_mem_r_en_o,
   output logic [ADDR_W-1:0] ext_mem_r_addr_o,
   input  logic [DATA_W-1:0] ext_mem_r_data_i
`ifdef IOB_RAM_T2P_FIFO_CTRL_ERR_EN
   ,
   input  logic              err_clr_i,
   output logic [1:0]        err_o
`endif
);

   localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              r_valid_q;
   logic              wr_acc, rd_acc;

   assign wr_acc = w_en_i & ~full_q;
   assign rd_acc = r_en_i & ~empty_q;

   // RAM enables are masked by reset so nothing is written or read in the reset cycle.
   assign ext_mem_clk_o    = clk_i;
   assign ext_mem_w_en_o   = wr_acc & ~rst_i;
   assign ext_mem_w_addr_o = w_ptr_q;
   assign ext_mem_w_data_o = w_data_i;
   assign ext_mem_r_en_o   = rd_acc & ~rst_i;
   assign ext_mem_r_addr_o = r_ptr_q;

   assign r_data_o  = ext_mem_r_data_i;
   assign r_valid_o = r_valid_q;
   assign r_empty_o = empty_q;
   assign w_full_o  = full_q;
   assign level_o   = level_q;

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      level_d = level_q;
      if (wr_acc) w_ptr_d = w_ptr_q + ADDR_W'(1);
      if (rd_acc) r_ptr_d = r_ptr_q + ADDR_W'(1);
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + (ADDR_W+1)'(1);
         2'b01:   level_d = level_q - (ADDR_W+1)'(1);
         default: level_d = level_q;
      endcase
      empty_d = (level_d == '0);
      full_d  = (level_d == DEPTH_L);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_ptr_q   <= '0;
         r_ptr_q   <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         r_valid_q <= 1'b0;
      end else begin
         w_ptr_q   <= w_ptr_d;
         r_ptr_q   <= r_ptr_d;
         level_q   <= level_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         r_valid_q <= rd_acc;
      end
   end

`ifdef IOB_RAM_T2P_FIFO_CTRL_ERR_EN
   logic [1:0] err_q, err_d;

   // A new error event in the clearing cycle wins over the clear.
   always_comb begin
      err_d = err_q;
      if (err_clr_i) err_d = 2'b00;
      if (w_en_i & full_q)  err_d[0] = 1'b1;
      if (r_en_i & empty_q) err_d[1] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 2'b00;
      else       err_q <= err_d;
   end

   assign err_o = err_q;
`endif

endmodule
